// File: rtl/regfile_pkg.sv
// Shared types, defaults and reset-mode encodings for the register file with scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

  // Reset-content modes
  localparam int unsigned RST_ZERO  = 0;
  localparam int unsigned RST_INDEX = 1;

  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue sets, retiring write clears, set beats clear.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD-1:0][AW-1:0]  ra,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          we,
  input  logic [NWR-1:0][AW-1:0]  wa,
  input  logic [NWR-1:0]          wb_clr,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  output logic                    iss_ready,
  output logic [NREG-1:0]         busy
);

  logic [NREG-1:0] busy_nxt;

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Readiness looks only at registered state; clears land before the set so set wins
  always_comb begin
    iss_ready = (iss_rd == '0) || !busy[iss_rd];
    busy_nxt  = busy;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we[k] && wb_clr[k] && (wa[k] != '0)) busy_nxt[wa[k]] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // A retiring write in flight this cycle hides the busy bit from readers when bypassing
  always_comb begin
    rd_busy = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      rd_busy[j] = (ra[j] != '0) && busy[ra[j]];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (we[k] && wb_clr[k] && (wa[k] == ra[j])) rd_busy[j] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a hazard scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned NREG       = NREG_DEF,
  parameter int unsigned AW         = $clog2(NREG),
  parameter int unsigned NRD        = 2,
  parameter int unsigned NWR        = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned RESET_INIT = RST_ZERO
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   ra,
  output logic [NRD-1:0][XLEN-1:0] rd,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           we,
  input  logic [NWR-1:0][AW-1:0]   wa,
  input  logic [NWR-1:0][XLEN-1:0] wd,
  input  logic [NWR-1:0]           wb_clr,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  output logic                     iss_ready,
  output logic [NREG-1:0]          busy
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0][XLEN-1:0] regs_nxt;

  function automatic logic [NREG-1:0][XLEN-1:0] reset_image();
    logic [NREG-1:0][XLEN-1:0] v;
    for (int unsigned i = 0; i < NREG; i++) begin
      v[i] = (RESET_INIT == RST_INDEX) ? XLEN'(i) : '0;
    end
    return v;
  endfunction

  // Ports applied in index order so the higher port wins a collision; x0 never written
  always_comb begin
    regs_nxt = regs;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we[k] && (wa[k] != '0)) regs_nxt[wa[k]] = wd[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) regs <= reset_image();
    else       regs <= regs_nxt;
  end

  always_comb begin
    rd = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      if (ra[j] != '0) begin
        rd[j] = regs[ra[j]];
        if (BYPASS != 0) begin
          for (int unsigned k = 0; k < NWR; k++) begin
            if (we[k] && (wa[k] == ra[j])) rd[j] = wd[k];
          end
        end
      end
    end
  end

  rf_scoreboard #(
    .NREG   (NREG),
    .AW     (AW),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .wb_clr    (wb_clr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .busy      (busy)
  );

endmodule
